bsg_counter_load_down_expire: RTL and testbench
===============================================

// Module: bsg_counter_load_down_expire
// PURPOSE
//  Loadable down-counter/timer; complement of the clear-and-count-up counter.
//  A value is loaded through a valid/ready handshake, decremented on tick_i and
//  signals expiry with a one-cycle pulse. Optional auto-reload re-arms it.
//  Used for timeouts, credit countdowns and periodic event generation.
// PARAMETERS
//  width_p        16  counter and load value width, >= 1
//  auto_reload_p  0   1: on expiry reload the last accepted value and keep running
// PORTS
//  clk_i         in   1        clock, rising edge
//  reset_n_i     in   1        reset, asynchronous, active-low
//  load_v_i      in   1        load request valid
//  load_val_i    in   width_p  value to load
//  load_ready_o  out  1        load accepted when load_v_i & load_ready_o
//  tick_i        in   1        decrement enable, sampled only in RUN
//  abort_i       in   1        stop the count; return to IDLE, no expiry
//  count_o       out  width_p  current count, registered
//  busy_o        out  1        1 in RUN
//  expire_o      out  1        registered one-cycle expiry pulse
// BEHAVIOUR
//  Reset (async, reset_n_i=0): state=IDLE, count_o=0, busy_o=0, expire_o=0,
//   reload_r=0. load_ready_o=1 while in reset. Outputs change immediately.
//  States: IDLE, RUN. load_ready_o = (state==IDLE). busy_o = (state==RUN).
//  expire_o defaults to 0 every cycle unless set below.
//  IDLE:
//   - load accepted, load_val_i!=0: count_o<=load_val_i, reload_r<=load_val_i,
//     ->RUN. count_o and busy_o valid the cycle after the handshake.
//   - load accepted, load_val_i==0: stay IDLE, count_o<=0, expire_o<=1.
//     RUN is never entered and reload_r is unchanged, so a zero load never
//     auto-reloads.
//   - tick_i and abort_i are ignored.
//  RUN:
//   - priority: abort_i > tick_i. load_v_i is ignored because ready=0.
//   - abort_i: ->IDLE, count_o<=0, expire_o stays 0, even if count_o==1.
//   - tick_i, count_o>1: count_o<=count_o-1.
//   - tick_i, count_o==1 (expiry):
//     - expire_o<=1.
//     - auto_reload_p=0: count_o<=0, ->IDLE.
//     - auto_reload_p=1: count_o<=reload_r, stay RUN; the period is reload_r ticks.
//   - no tick_i: hold.
//  count_o never wraps. RUN always holds count_o>=1, so the down-step never
//   underflows. Width: count_o - 1 is width_p bits.
//  Loading all-ones (2^width_p-1) is legal and takes that many ticks.
//  Simulation-only check: error $display on any X on tick_i/load_v_i/abort_i
//   after reset deasserts.
// TESTING
//  1. Load 3, tick_i=1 every cycle -> count_o 3,2,1,0; expire_o=1 exactly in the
//     cycle count_o==0; busy_o=0 and load_ready_o=1 from then on.
//  2. Load 0 -> next cycle expire_o=1, busy_o=0, count_o=0; no further pulses.
//  3. auto_reload_p=1, load 2, tick every cycle -> count_o 2,1,2,1,...;
//     expire_o pulses every 2nd cycle; abort_i -> IDLE with count_o=0 and no pulse.
//  4. Load 5, tick_i every other cycle -> expire after 5 ticks (10 cycles);
//     load_v_i asserted during RUN is not accepted (load_ready_o=0).
//  5. count_o==1 with abort_i=1 and tick_i=1 together -> IDLE, expire_o stays 0.
//  6. Assert reset_n_i=0 mid-RUN between clock edges (count_o=7) -> count_o=0,
//     busy_o=0, expire_o=0 immediately; after release, load 1 + tick -> one pulse.

Source files
------------

// File: rtl/bsg_counter_load_down_expire.sv
// bsg_counter_load_down_expire: loadable down-counter that emits a one-cycle expiry pulse, with optional auto-reload.
module bsg_counter_load_down_expire #(
  parameter int width_p       = 16,
  parameter bit auto_reload_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_v_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               load_ready_o,
  input  logic               tick_i,
  input  logic               abort_i,
  output logic [width_p-1:0] count_o,
  output logic               busy_o,
  output logic               expire_o
);
  typedef enum logic {idle_s, run_s} state_e;
  state_e state_q, state_d;
  logic [width_p-1:0] count_q, count_d, reload_q, reload_d;
  logic expire_q, expire_d;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;
    if (state_q == idle_s) begin
      if (load_v_i) begin
        count_d  = load_val_i;
        reload_d = (load_val_i != '0) ? load_val_i : reload_q;
        state_d  = (load_val_i != '0) ? run_s : idle_s;
        expire_d = (load_val_i == '0);
      end
    end else if (abort_i) begin
      state_d = idle_s;
      count_d = '0;
    end else if (tick_i) begin
      // RUN never holds zero, so the expiry test at one keeps the decrement from underflowing
      if (count_q == width_p'(1)) begin
        expire_d = 1'b1;
        count_d  = auto_reload_p ? reload_q : '0;
        state_d  = auto_reload_p ? run_s : idle_s;
      end else begin
        count_d = count_q - width_p'(1);
      end
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= idle_s;
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end
  assign load_ready_o = (state_q == idle_s);
  assign busy_o       = (state_q == run_s);
  assign count_o      = count_q;
  assign expire_o     = expire_q;
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i)
      assert (!$isunknown({tick_i, load_v_i, abort_i}))
      else $error("bsg_counter_load_down_expire: X on control input");
  end
`endif
endmodule

// File: tb/tb_bsg_counter_load_down_expire.sv
// tb_bsg_counter_load_down_expire: directed vectors for a one-shot 16-bit instance and an auto-reload 4-bit instance.
module tb_bsg_counter_load_down_expire;
  logic clk = 1'b0, reset_n_i = 1'b0;
  logic lv = 1'b0, tick = 1'b0, abort = 1'b0;
  logic [15:0] val = '0, cnt;
  logic rdy, busy, expo;
  logic a_lv = 1'b0, a_tick = 1'b0, a_abort = 1'b0;
  logic [3:0] a_val = '0, a_cnt;
  logic a_rdy, a_busy, a_exp;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  bsg_counter_load_down_expire #(.width_p(16), .auto_reload_p(1'b0)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .load_v_i(lv), .load_val_i(val), .load_ready_o(rdy),
    .tick_i(tick), .abort_i(abort), .count_o(cnt), .busy_o(busy), .expire_o(expo));
  bsg_counter_load_down_expire #(.width_p(4), .auto_reload_p(1'b1)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n_i), .load_v_i(a_lv), .load_val_i(a_val), .load_ready_o(a_rdy),
    .tick_i(a_tick), .abort_i(a_abort), .count_o(a_cnt), .busy_o(a_busy), .expire_o(a_exp));
  typedef struct {
    string nm;
    logic lv, tick, abort;
    logic [15:0] val, cnt;
    logic busy, expo, rdy;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(string nm, logic l, logic [15:0] v, logic t, logic a,
                              logic [15:0] c, logic b, logic e, logic r);
    vec_t x;
    x.nm = nm; x.lv = l; x.val = v; x.tick = t; x.abort = a;
    x.cnt = c; x.busy = b; x.expo = e; x.rdy = r;
    return x;
  endfunction
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic acyc(input string nm, input logic l, input logic [3:0] v, input logic t,
                      input logic a, input logic [3:0] c, input logic b, input logic e);
    a_lv = l; a_val = v; a_tick = t; a_abort = a;
    cyc();
    check({nm, ".cnt"}, 32'(a_cnt), 32'(c));
    check({nm, ".busy"}, 32'(a_busy), 32'(b));
    check({nm, ".exp"}, 32'(a_exp), 32'(e));
  endtask
  initial begin
    vecs.push_back(mk("t1_load3", 1, 3, 0, 0, 3, 1, 0, 0));
    vecs.push_back(mk("t1_tick2", 0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("t1_tick1", 0, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk("t1_expire", 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("t1_after", 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t2_load0", 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("t2_quiet", 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t2_idle_ign", 0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk("t5_load2", 1, 2, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("t5_tick1", 0, 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk("t5_abort_tick", 0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk("t5_quiet", 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t4_load5", 1, 5, 0, 0, 5, 1, 0, 0));
    for (int k = 4; k >= 0; k--) begin
      vecs.push_back(mk("t4_hold_ldreq", 1, 9, 0, 0, 16'(k + 1), 1, 0, 0));
      vecs.push_back(mk("t4_tick", 0, 0, 1, 0, 16'(k), k != 0, k == 0, k == 0));
    end
    #12;
    check("rst.cnt", 32'(cnt), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.exp", 32'(expo), 0);
    check("rst.rdy", 32'(rdy), 1);
    check("rst.a_rdy", 32'(a_rdy), 1);
    @(negedge clk);
    reset_n_i = 1'b1;
    foreach (vecs[i]) begin
      lv = vecs[i].lv; val = vecs[i].val; tick = vecs[i].tick; abort = vecs[i].abort;
      cyc();
      check({vecs[i].nm, ".cnt"}, 32'(cnt), 32'(vecs[i].cnt));
      check({vecs[i].nm, ".busy"}, 32'(busy), 32'(vecs[i].busy));
      check({vecs[i].nm, ".exp"}, 32'(expo), 32'(vecs[i].expo));
      check({vecs[i].nm, ".rdy"}, 32'(rdy), 32'(vecs[i].rdy));
    end
    lv = 0; tick = 0; abort = 0;
    acyc("t3_load2", 1, 2, 0, 0, 2, 1, 0);
    acyc("t3_tick_a", 0, 0, 1, 0, 1, 1, 0);
    acyc("t3_reload_a", 0, 0, 1, 0, 2, 1, 1);
    acyc("t3_tick_b", 0, 0, 1, 0, 1, 1, 0);
    acyc("t3_reload_b", 0, 0, 1, 0, 2, 1, 1);
    acyc("t3_hold", 1, 7, 0, 0, 2, 1, 0);
    acyc("t3_abort", 0, 0, 1, 1, 0, 0, 0);
    check("t3_abort.rdy", 32'(a_rdy), 1);
    acyc("az_load0", 1, 0, 0, 0, 0, 0, 1);
    acyc("az_noreload", 0, 0, 1, 0, 0, 0, 0);
    acyc("max_load", 1, 15, 0, 0, 15, 1, 0);
    for (int k = 14; k >= 1; k--) acyc("max_tick", 0, 0, 1, 0, 4'(k), 1, 0);
    acyc("max_reload", 0, 0, 1, 0, 15, 1, 1);
    acyc("max_abort", 0, 0, 0, 1, 0, 0, 0);
    a_abort = 0;
    lv = 1; val = 7;
    cyc();
    lv = 0;
    check("t6_load7.cnt", 32'(cnt), 7);
    #3 reset_n_i = 1'b0;
    #1;
    check("t6_rst.cnt", 32'(cnt), 0);
    check("t6_rst.busy", 32'(busy), 0);
    check("t6_rst.exp", 32'(expo), 0);
    check("t6_rst.rdy", 32'(rdy), 1);
    #2 reset_n_i = 1'b1;
    lv = 1; val = 1;
    cyc();
    check("t6_load1.cnt", 32'(cnt), 1);
    check("t6_load1.busy", 32'(busy), 1);
    lv = 0; tick = 1;
    cyc();
    check("t6_exp.exp", 32'(expo), 1);
    check("t6_exp.busy", 32'(busy), 0);
    check("t6_exp.cnt", 32'(cnt), 0);
    tick = 0;
    cyc();
    check("t6_one_pulse.exp", 32'(expo), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
